// File: rtl/smc_host_if.sv
// smc_host_if: serial host front end for the combinational SMC core.
// Operand beats arrive one transistor at a time over a valid/ready stream.
// Six beats are staged in shadow registers. They are then committed in one
// step to stable SMC drive registers. After SETTLE cycles the SMC result is
// sampled and returned on a valid/ready result stream.
// Optional feature macro: SMC_HOST_CHECK_EN. When it is defined, the block
// adds the expected-result compare ports in_exp, res_err and err_cnt.
module smc_host_if #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] in_data,
    input  logic [1:0] in_mode,
    output logic [2:0] W_0,
    output logic [2:0] W_1,
    output logic [2:0] W_2,
    output logic [2:0] W_3,
    output logic [2:0] W_4,
    output logic [2:0] W_5,
    output logic [2:0] V_GS_0,
    output logic [2:0] V_GS_1,
    output logic [2:0] V_GS_2,
    output logic [2:0] V_GS_3,
    output logic [2:0] V_GS_4,
    output logic [2:0] V_GS_5,
    output logic [2:0] V_DS_0,
    output logic [2:0] V_DS_1,
    output logic [2:0] V_DS_2,
    output logic [2:0] V_DS_3,
    output logic [2:0] V_DS_4,
    output logic [2:0] V_DS_5,
    output logic [1:0] mode,
    input  logic [9:0] out_n,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [9:0] res_data
`ifdef SMC_HOST_CHECK_EN
    ,
    input  logic [9:0] in_exp,
    output logic       res_err,
    output logic [7:0] err_cnt
`endif
);

    // Settle count as loaded into the 4-bit down-counter (legal 1..15).
    localparam logic [3:0] SETTLE_C = 4'(SETTLE);
    localparam logic [2:0] LAST_BEAT = 3'd5;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t     state_r;
    logic [2:0] beat_idx_r;
    logic [3:0] settle_cnt_r;
    logic       in_ready_r;

    // Beats 0..4 are staged here; beat 5 is taken straight from in_data at
    // the commit edge, so a sixth shadow slot would never be read.
    logic [8:0] shadow_r [0:4];
    logic [1:0] shadow_mode_r;

    // Stable SMC drives: one {W, V_GS, V_DS} word per transistor.
    logic [8:0] drive_r [0:5];
    logic [1:0] mode_r;

    logic       res_valid_r;
    logic [9:0] res_data_r;

`ifdef SMC_HOST_CHECK_EN
    logic [9:0] exp_r;
    logic       res_err_r;
    logic [7:0] err_cnt_r;
`endif

    // Frame sequencer: beat staging, commit, settle timing and result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_LOAD;
            beat_idx_r    <= 3'd0;
            settle_cnt_r  <= 4'd0;
            in_ready_r    <= 1'b1;
            shadow_mode_r <= 2'd0;
            mode_r        <= 2'd0;
            res_valid_r   <= 1'b0;
            res_data_r    <= 10'd0;
            for (int i = 0; i < 5; i++) begin
                shadow_r[i] <= 9'd0;
            end
            for (int i = 0; i < 6; i++) begin
                drive_r[i] <= 9'd0;
            end
`ifdef SMC_HOST_CHECK_EN
            exp_r     <= 10'd0;
            res_err_r <= 1'b0;
            err_cnt_r <= 8'd0;
`endif
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (in_valid && in_ready_r) begin
                        if (beat_idx_r == LAST_BEAT) begin
                            // Commit the whole frame at once so the SMC
                            // never sees a half-updated operand set.
                            for (int i = 0; i < 5; i++) begin
                                drive_r[i] <= shadow_r[i];
                            end
                            drive_r[5]   <= in_data;
                            mode_r       <= shadow_mode_r;
                            beat_idx_r   <= 3'd0;
                            settle_cnt_r <= SETTLE_C;
                            in_ready_r   <= 1'b0;
                            state_r      <= ST_SETTLE;
`ifdef SMC_HOST_CHECK_EN
                            exp_r        <= in_exp;
`endif
                        end else if (beat_idx_r < LAST_BEAT) begin
                            shadow_r[beat_idx_r] <= in_data;
                            if (beat_idx_r == 3'd0) begin
                                shadow_mode_r <= in_mode;
                            end else begin
                                shadow_mode_r <= shadow_mode_r;
                            end
                            beat_idx_r <= beat_idx_r + 3'd1;
                        end else begin
                            // Unreachable index: restart the frame cleanly.
                            beat_idx_r <= 3'd0;
                        end
                    end else begin
                        beat_idx_r <= beat_idx_r;
                    end
                end

                ST_SETTLE: begin
                    // A count of 0 is unreachable; treat it like 1 so the
                    // sequencer can never stall in SETTLE.
                    if (settle_cnt_r <= 4'd1) begin
                        settle_cnt_r <= 4'd0;
                        res_data_r   <= out_n;
                        res_valid_r  <= 1'b1;
                        state_r      <= ST_HOLD;
`ifdef SMC_HOST_CHECK_EN
                        res_err_r <= (out_n != exp_r);
                        if ((out_n != exp_r) && (err_cnt_r != 8'hFF)) begin
                            err_cnt_r <= err_cnt_r + 8'd1;
                        end else begin
                            err_cnt_r <= err_cnt_r;
                        end
`endif
                    end else begin
                        settle_cnt_r <= settle_cnt_r - 4'd1;
                    end
                end

                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_LOAD;
                    end else begin
                        res_valid_r <= 1'b1;
                    end
                end

                default: begin
                    // Illegal encoding: return to a safe idle frame start.
                    state_r      <= ST_LOAD;
                    beat_idx_r   <= 3'd0;
                    settle_cnt_r <= 4'd0;
                    in_ready_r   <= 1'b1;
                    res_valid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign mode      = mode_r;

    assign W_0    = drive_r[0][8:6];
    assign V_GS_0 = drive_r[0][5:3];
    assign V_DS_0 = drive_r[0][2:0];
    assign W_1    = drive_r[1][8:6];
    assign V_GS_1 = drive_r[1][5:3];
    assign V_DS_1 = drive_r[1][2:0];
    assign W_2    = drive_r[2][8:6];
    assign V_GS_2 = drive_r[2][5:3];
    assign V_DS_2 = drive_r[2][2:0];
    assign W_3    = drive_r[3][8:6];
    assign V_GS_3 = drive_r[3][5:3];
    assign V_DS_3 = drive_r[3][2:0];
    assign W_4    = drive_r[4][8:6];
    assign V_GS_4 = drive_r[4][5:3];
    assign V_DS_4 = drive_r[4][2:0];
    assign W_5    = drive_r[5][8:6];
    assign V_GS_5 = drive_r[5][5:3];
    assign V_DS_5 = drive_r[5][2:0];

`ifdef SMC_HOST_CHECK_EN
    assign res_err = res_err_r;
    assign err_cnt = err_cnt_r;
`endif

endmodule

// File: doc/smc_host_if.md
# smc_host_if

Sequential host-side front end for the SMC block. It accepts the six transistor operand sets and the mode one beat at a time over a valid/ready stream. It then drives the SMC's 18 parallel operand ports plus `mode` from stable registers and waits a fixed settle time. Finally it samples `out_n` and returns it on a valid/ready result stream. It is the initiator/reader counterpart to SMC and sits between a serial test/host source and the combinational SMC core.

## Interface
Parameters:
- `SETTLE`, default 1: cycles between driving SMC operands and sampling `out_n`; legal range 1..15.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  9  `{W[8:6], V_GS[5:3], V_DS[2:0]}` for the current transistor.
- `in_mode`  in  2  mode; sampled only on beat 0.
- `W_0..W_5`, `V_GS_0..V_GS_5`, `V_DS_0..V_DS_5`  out  3 each  registered SMC operand drives.
- `mode`  out  2  registered SMC mode drive.
- `out_n`  in  10  SMC result.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  downstream accepts result.
- `res_data`  out  10  captured `out_n`.
- `in_exp`, `res_err`, `err_cnt`: see Configuration.

## Operation
- States: LOAD, SETTLE, HOLD.
- LOAD:
  - `in_ready`=1.
  - Each accepted beat (`in_valid && in_ready` at an edge) writes `in_data` into shadow slot `beat_idx` (0..5), then increments `beat_idx`.
  - Beat 0 also writes `in_mode` into the shadow mode.
  - The accepting edge of beat 5 copies all shadow slots and the shadow mode into the SMC drive registers in one step, clears `beat_idx` to 0, loads `settle_cnt`=SETTLE, and moves to SETTLE.
- SETTLE:
  - `in_ready`=0.
  - `settle_cnt` decrements each edge.
  - At the edge where `settle_cnt`==1, `out_n` is captured into `res_data`, `res_valid` goes to 1, and the state moves to HOLD.
- HOLD:
  - `in_ready`=0.
  - `res_valid`=1 and `res_data` stay stable until `res_valid && res_ready`.
  - That edge clears `res_valid` and moves to LOAD.
- The SMC drive registers change only at the beat-5 edge. They hold the last frame's values through SETTLE, HOLD and the next LOAD, so SMC inputs never toggle while being sampled.
- Beats are consumed strictly in order 0→5. No partial-frame flush exists; an incomplete frame waits indefinitely.
- Async reset at any point, including mid-frame or mid-HOLD:
  - state=LOAD, `beat_idx`=0, `settle_cnt`=0.
  - Shadow and drive registers = 0, `mode`=0.
  - `res_valid`=0, `res_data`=0.
  - Partial frame discarded.
  - `in_ready`=1 once `rst_n` deasserts.
- Reset values of outputs: `in_ready`=1, all `W_*`/`V_GS_*`/`V_DS_*`=0, `mode`=0, `res_valid`=0, `res_data`=0, `res_err`=0, `err_cnt`=0.

## Timing
- Beat 5 accepted at edge T.
  - Drive registers are valid after T.
  - `out_n` is sampled at edge T+SETTLE.
  - `res_valid` is high from T+SETTLE onward.
- Minimum frame period with `res_ready` held 1 is 6 + SETTLE + 1 cycles.
- `in_ready` is a pure function of state (Moore); no combinational path from `in_valid` to `in_ready`.
- `res_valid` and `res_data` are registered. `res_ready` low for N cycles extends HOLD by N cycles.
- Downstream logic must meet SMC combinational delay within SETTLE clock periods.

## Configuration
- Macro `SMC_HOST_CHECK_EN`.
- Defined:
  - Ports `in_exp` (in, 10), `res_err` (out, 1) and `err_cnt` (out, 8) exist.
  - `in_exp` is sampled on beat 5.
  - At the capture edge, `res_err` = (`out_n` != sampled expectation) and is held with `res_data`.
  - `err_cnt` increments on each mismatch and saturates at 255.
- Undefined: these three ports and their logic are absent; all other behaviour is identical.

## Test plan
- Reset mid-frame: after 3 beats assert `rst_n`=0 → `in_ready`=1, all drives 0, `res_valid`=0. Then send 6 full beats → one result, using only the new beats.
- Frame load with SMC stub returning `{W_0,V_GS_0,V_DS_0,1'b0}`: beats 0..5 `in_data`=9'o123,9'o234,9'o345,9'o456,9'o567,9'o671, `in_mode`=2'b10 → `W_0`=1, `V_GS_0`=2, `V_DS_0`=3, …, `W_5`=6, `V_GS_5`=7, `V_DS_5`=1, `mode`=2'b10, `res_data`=10'h0A6.
- Latency: SETTLE=3, `res_ready`=1 → `res_valid` rises exactly 3 edges after the beat-5 edge and stays high for 1 cycle; next `in_ready` is 1 on the following cycle.
- Backpressure: `res_ready`=0 for 20 cycles → `res_data` stable, `in_ready`=0 and `in_valid` ignored throughout, drives unchanged.
- Real SMC, all beats 9'o111, mode 2'b00 → `res_data`=0; with a new frame, drives update only at the beat-5 edge.
- With `SMC_HOST_CHECK_EN`: `in_exp`=10'h001 vs stub output 10'h000 → `res_err`=1, `err_cnt`=1; 300 mismatching frames → `err_cnt`=255.
